mcu_reg_arbiter: RTL and testbench
==================================

# mcu_reg_arbiter

Shares the single internal register-bank port between two masters: the MCU async-memory bridge (strobe-driven, cannot be stalled) and an internal FPGA master (req/ack handshake, e.g. the motion sequencer). MCU accesses always win. Internal accesses are issued in idle slots. A tag pipeline routes read data back to the correct master. Sits between the MCU bus bridge and the register bank/decoder.

## Interface
- RD_LAT, 2 — register-bank read latency in clk cycles (1..4).
- STARVE_LIM, 64 — cycles an internal request may stay pending before the starvation flag sets (2..255).
- clk  in  1  clock.
- aclr  in  1  asynchronous reset, active-high.
- m_addr  in  16  MCU address.
- m_wr  in  1  MCU write strobe, one clk per access.
- m_rd  in  1  MCU read strobe, one clk per access.
- m_wrdata  in  16  MCU write data.
- m_rddata  out  16  MCU read data.
- m_rdvalid  out  1  m_rddata valid pulse.
- i_req  in  1  internal request; held until i_ack.
- i_we  in  1  internal write (1) / read (0); stable while i_req.
- i_addr  in  16  internal address; stable while i_req.
- i_wrdata  in  16  internal write data; stable while i_req.
- i_ack  out  1  one-cycle completion pulse.
- i_rddata  out  16  internal read data, valid with i_ack on reads.
- starve  out  1  sticky: an internal request waited ≥ STARVE_LIM cycles.
- starve_clr  in  1  clears starve.
- s_addr  out  16  bank address.
- s_we  out  1  bank write strobe.
- s_re  out  1  bank read strobe.
- s_wrdata  out  16  bank write data.
- s_rddata  in  16  bank read data, valid RD_LAT cycles after s_re.

## Operation
- All outputs are registered. Reset values: every output is 0. The FSM is in IDLE and the tag pipe is cleared.
- Issue stage, evaluated each cycle:
  - m_wr or m_rd asserted: forward the MCU access to s_* on the next cycle.
  - Else, internal FSM in ISSUE: forward the internal access.
  - Else: s_we = s_re = 0.
- m_wr and m_rd asserted together is illegal. m_wr takes precedence; the read is dropped.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}, loaded on each issued read.
  - At the output, owner = M drives m_rddata/m_rdvalid.
  - Owner = I drives i_rddata/i_ack.
- Internal FSM:
  - IDLE → ISSUE on i_req.
  - ISSUE stays in ISSUE while the MCU holds the slot.
  - ISSUE, slot granted, write → DONE. i_ack fires the cycle after s_we.
  - ISSUE, slot granted, read → WAIT_DATA.
  - WAIT_DATA → DONE when the tag output is {1, I}. i_ack fires with i_rddata.
  - DONE → IDLE. i_req must drop in the i_ack cycle; it is sampled again only from IDLE.
- Starvation counter:
  - 8-bit, counts cycles spent in ISSUE and saturates at 255.
  - Resets on leaving ISSUE.
  - Counter ≥ STARVE_LIM sets starve.
  - starve_clr clears starve. If set and clear coincide, set wins.
  - The MCU is never throttled; starve is diagnostic only.
- aclr mid-operation: the tag pipe flushes, in-flight read data is discarded, and no ack is produced.
  - The internal master must re-request after reset.

## Timing
- MCU access: strobe in cycle T → s_* in T+1.
  - Read data: m_rdvalid in T+1+RD_LAT+1 (one output register).
- Internal write, no conflict: i_req at T → s_we T+2 → i_ack T+3.
- Internal read, no conflict: s_re T+2 → i_ack T+2+RD_LAT+1.
- Back-to-back MCU strobes every cycle are sustained at full rate; the internal side waits indefinitely.
- Issued reads from both owners may interleave in the pipe; order of return equals order of issue.

## Test plan
- Reset: assert aclr mid-stream → all outputs 0 and no stale m_rdvalid/i_ack after release.
- MCU only: m_wr addr 0x0010 data 0xA5A5, then m_rd 0x0010, with the bank model returning 0xA5A5 → s_we at T+1; m_rdvalid with 0xA5A5 at T+1+RD_LAT+1.
- Internal read, idle bus: i_req, i_we = 0, addr 0x0020, bank returns 0x1234 → i_ack exactly once with i_rddata = 0x1234 at the computed latency.
- Conflict: MCU read in the same cycle as an internal read request → MCU issued first, internal one cycle later; each master receives only its own data, with no swap.
- Starvation: STARVE_LIM = 4, MCU strobes 6 consecutive cycles while i_req is held → starve = 1 after 4 pending cycles; internal access completes after the MCU burst; starve_clr → 0.
- Illegal m_wr and m_rd together → only the write is issued and no m_rdvalid.

Source files
------------

// File: rtl/mcu_reg_arbiter.sv
// mcu_reg_arbiter: shares the single register-bank port between the MCU
// async-memory bridge and an internal req/ack master. The MCU always wins.
// Internal accesses use idle slots. A tag pipe steers read data back to the
// master that issued the read.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no internal access in progress
// ISSUE     | internal access waiting for a bank slot not taken by the MCU
// WAIT_DATA | internal read issued, waiting for its tag at the pipe output
// DONE      | internal access finishing; i_req is sampled again only in IDLE
module mcu_reg_arbiter #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_LIM = 64
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic [15:0] m_addr,
    input  logic        m_wr,
    input  logic        m_rd,
    input  logic [15:0] m_wrdata,
    output logic [15:0] m_rddata,
    output logic        m_rdvalid,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wrdata,
    output logic        i_ack,
    output logic [15:0] i_rddata,
    output logic        starve,
    input  logic        starve_clr,
    output logic [15:0] s_addr,
    output logic        s_we,
    output logic        s_re,
    output logic [15:0] s_wrdata,
    input  logic [15:0] s_rddata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    state_t            state;
    state_t            state_nxt;
    logic              ack_nxt;
    logic              m_go;
    logic              i_grant;
    logic              s_own;      // owner of the access now on s_*: 1 = internal
    logic              wr_q;       // granted internal access was a write
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_o;
    logic              tag_hit_m;
    logic              tag_hit_i;
    logic [7:0]        wait_cnt;

    assign m_go      = m_wr | m_rd;
    assign i_grant   = (state == ISSUE) && !m_go;
    assign tag_hit_m = tag_v[RD_LAT-1] & ~tag_o[RD_LAT-1];
    assign tag_hit_i = tag_v[RD_LAT-1] &  tag_o[RD_LAT-1];

    // Issue stage: MCU strobe owns the slot, otherwise a pending internal access.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s_addr   <= '0;
            s_wrdata <= '0;
            s_we     <= 1'b0;
            s_re     <= 1'b0;
            s_own    <= 1'b0;
            wr_q     <= 1'b0;
        end else if (m_go) begin
            // a simultaneous read strobe is dropped in favour of the write
            s_addr   <= m_addr;
            s_wrdata <= m_wrdata;
            s_we     <= m_wr;
            s_re     <= ~m_wr;
            s_own    <= 1'b0;
        end else if (i_grant) begin
            s_addr   <= i_addr;
            s_wrdata <= i_wrdata;
            s_we     <= i_we;
            s_re     <= ~i_we;
            s_own    <= 1'b1;
            wr_q     <= i_we;
        end else begin
            s_we     <= 1'b0;
            s_re     <= 1'b0;
        end
    end

    // Tag pipe: follows each issued read so its last stage lines up with s_rddata.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            tag_v <= '0;
            tag_o <= '0;
        end else begin
            tag_v[0] <= s_re;
            tag_o[0] <= s_own;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_o[k] <= tag_o[k-1];
            end
        end
    end

    // Return registers: capture bank data for whichever master owns the tag.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            m_rddata  <= '0;
            m_rdvalid <= 1'b0;
            i_rddata  <= '0;
            i_ack     <= 1'b0;
        end else begin
            m_rdvalid <= tag_hit_m;
            i_ack     <= ack_nxt;
            if (tag_hit_m) begin
                m_rddata <= s_rddata;
            end
            if (tag_hit_i) begin
                i_rddata <= s_rddata;
            end
        end
    end

    // Internal FSM state register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Internal FSM next state and ack request.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                // a write ack lands while already back in IDLE; ignore the
                // i_req the master is still holding in that cycle
                if (i_req && !i_ack) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_go) begin
                    state_nxt = i_we ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (tag_hit_i) begin
                    state_nxt = DONE;
                    ack_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ack_nxt   = wr_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation counter: cycles spent in ISSUE, saturating, cleared on exit.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky starvation flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            starve <= 1'b0;
        end else if (wait_cnt >= LIM) begin
            starve <= 1'b1;
        end else if (starve_clr) begin
            starve <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcu_reg_arbiter.sv
// Bench for mcu_reg_arbiter: directed stimulus pushes expected bank accesses,
// read returns and point samples into queues; one monitor pops and compares.
module tb_mcu_reg_arbiter;

    localparam int RD_LAT     = 2;
    localparam int STARVE_LIM = 4;

    logic        clk        = 1'b0;
    logic        aclr       = 1'b1;
    logic [15:0] m_addr     = '0;
    logic        m_wr       = 1'b0;
    logic        m_rd       = 1'b0;
    logic [15:0] m_wrdata   = '0;
    logic [15:0] m_rddata;
    logic        m_rdvalid;
    logic        i_req      = 1'b0;
    logic        i_we       = 1'b0;
    logic [15:0] i_addr     = '0;
    logic [15:0] i_wrdata   = '0;
    logic        i_ack;
    logic [15:0] i_rddata;
    logic        starve;
    logic        starve_clr = 1'b0;
    logic [15:0] s_addr;
    logic        s_we;
    logic        s_re;
    logic [15:0] s_wrdata;
    logic [15:0] s_rddata;

    mcu_reg_arbiter #(
        .RD_LAT     (RD_LAT),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .m_addr     (m_addr),
        .m_wr       (m_wr),
        .m_rd       (m_rd),
        .m_wrdata   (m_wrdata),
        .m_rddata   (m_rddata),
        .m_rdvalid  (m_rdvalid),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wrdata   (i_wrdata),
        .i_ack      (i_ack),
        .i_rddata   (i_rddata),
        .starve     (starve),
        .starve_clr (starve_clr),
        .s_addr     (s_addr),
        .s_we       (s_we),
        .s_re       (s_re),
        .s_wrdata   (s_wrdata),
        .s_rddata   (s_rddata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: writes land in mem, reads return RD_LAT cycles after s_re.
    logic [15:0] mem [256];
    logic [15:0] rpipe [RD_LAT];
    logic        bank_init = 1'b0;
    always @(posedge clk) begin
        if (!bank_init) begin
            mem[8'h20] <= 16'h1234;
            bank_init  <= 1'b1;
        end else if (s_we) begin
            mem[s_addr[7:0]] <= s_wrdata;
        end
        rpipe[0] <= s_re ? mem[s_addr[7:0]] : 16'hDEAD;
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign s_rddata = rpipe[RD_LAT-1];

    typedef struct { int cyc; logic we; logic re; logic [15:0] addr; logic [15:0] wdata; } bus_t;
    typedef struct { int cyc; logic chk; logic [15:0] data; } rsp_t;
    typedef struct { int cyc; int id; logic [15:0] val; } pt_t;

    bus_t bus_q[$];
    rsp_t m_q[$];
    rsp_t i_q[$];
    pt_t  pt_q[$];

    function automatic void exp_bus(int c, logic we, logic [15:0] a, logic [15:0] d);
        bus_t e;
        e.cyc = c; e.we = we; e.re = ~we; e.addr = a; e.wdata = d;
        bus_q.push_back(e);
    endfunction

    function automatic void exp_m(int c, logic [15:0] d);
        rsp_t e;
        e.cyc = c; e.chk = 1'b1; e.data = d;
        m_q.push_back(e);
    endfunction

    function automatic void exp_i(int c, logic chk, logic [15:0] d);
        rsp_t e;
        e.cyc = c; e.chk = chk; e.data = d;
        i_q.push_back(e);
    endfunction

    // id 0: starve flag value, id 1: OR of every output (reset check)
    function automatic void exp_pt(int c, int id, logic [15:0] v);
        pt_t e;
        e.cyc = c; e.id = id; e.val = v;
        pt_q.push_back(e);
    endfunction

    logic any_out;
    assign any_out = |{m_rddata, m_rdvalid, i_ack, i_rddata, starve,
                       s_addr, s_we, s_re, s_wrdata};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        done  = 1'b0;
    bus_t        b;
    rsp_t        r;
    pt_t         p;
    logic [15:0] act;

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (s_we || s_re) begin
            n_cmp++;
            if (bus_q.size() == 0) begin
                n_bad++;
                $display("FAIL bus_unexpected: got we=%0d re=%0d addr=%h at cyc %0d, want no access",
                         s_we, s_re, s_addr, cyc);
            end else begin
                b = bus_q.pop_front();
                if (b.cyc != cyc || b.we != s_we || b.re != s_re || b.addr != s_addr ||
                    (b.we && b.wdata != s_wrdata)) begin
                    n_bad++;
                    $display("FAIL bus: got cyc=%0d we=%0d re=%0d addr=%h wd=%h, want cyc=%0d we=%0d re=%0d addr=%h wd=%h",
                             cyc, s_we, s_re, s_addr, s_wrdata, b.cyc, b.we, b.re, b.addr, b.wdata);
                end
            end
        end
        if (m_rdvalid) begin
            n_cmp++;
            if (m_q.size() == 0) begin
                n_bad++;
                $display("FAIL m_rdvalid_unexpected: got data=%h at cyc %0d, want no return", m_rddata, cyc);
            end else begin
                r = m_q.pop_front();
                if (r.cyc != cyc || r.data != m_rddata) begin
                    n_bad++;
                    $display("FAIL m_read: got cyc=%0d data=%h, want cyc=%0d data=%h",
                             cyc, m_rddata, r.cyc, r.data);
                end
            end
        end
        if (i_ack) begin
            n_cmp++;
            if (i_q.size() == 0) begin
                n_bad++;
                $display("FAIL i_ack_unexpected: got ack at cyc %0d, want no ack", cyc);
            end else begin
                r = i_q.pop_front();
                if (r.cyc != cyc || (r.chk && r.data != i_rddata)) begin
                    n_bad++;
                    $display("FAIL i_ack: got cyc=%0d data=%h, want cyc=%0d data=%h",
                             cyc, i_rddata, r.cyc, r.data);
                end
            end
        end
        while (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
            p   = pt_q.pop_front();
            act = (p.id == 0) ? {15'b0, starve} : {15'b0, any_out};
            n_cmp++;
            if (p.cyc != cyc || act != p.val) begin
                n_bad++;
                $display("FAIL %s: got %0d at cyc %0d, want %0d at cyc %0d",
                         (p.id == 0) ? "starve" : "reset_zero", act, cyc, p.val, p.cyc);
            end
        end
        if (done) begin
            n_cmp++;
            if (bus_q.size() != 0) begin
                n_bad++;
                $display("FAIL bus_missing: got %0d expected accesses unseen, want 0", bus_q.size());
            end
            n_cmp++;
            if (m_q.size() != 0) begin
                n_bad++;
                $display("FAIL m_read_missing: got %0d returns unseen, want 0", m_q.size());
            end
            n_cmp++;
            if (i_q.size() != 0) begin
                n_bad++;
                $display("FAIL i_ack_missing: got %0d acks unseen, want 0", i_q.size());
            end
            n_cmp++;
            if (pt_q.size() != 0) begin
                n_bad++;
                $display("FAIL sample_missing: got %0d samples unchecked, want 0", pt_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, want finish before 300000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic mcu(logic wr, logic rd, logic [15:0] a, logic [15:0] d);
        m_wr = wr; m_rd = rd; m_addr = a; m_wrdata = d;
        tick();
        m_wr = 1'b0; m_rd = 1'b0;
    endtask

    task automatic mcu_burst(int n, logic [15:0] a0);
        for (int k = 0; k < n; k++) mcu(1'b1, 1'b0, a0 + 16'(k), 16'hC000 + 16'(k));
    endtask

    // Holds i_req until i_ack (bounded); drops it in the ack cycle.
    task automatic int_acc(logic we, logic [15:0] a, logic [15:0] d);
        i_req = 1'b1; i_we = we; i_addr = a; i_wrdata = d;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (i_ack) break;
        end
        i_req = 1'b0;
    endtask

    int t;

    initial begin
        // reset state
        idle(2);
        exp_pt(cyc, 1, 16'd0);
        tick();
        aclr = 1'b0;
        idle(2);

        // MCU write then read of the same address
        t = cyc;
        exp_bus(t + 1, 1'b1, 16'h0010, 16'hA5A5);
        mcu(1'b1, 1'b0, 16'h0010, 16'hA5A5);
        t = cyc;
        exp_bus(t + 1, 1'b0, 16'h0010, 16'h0000);
        exp_m(t + 2 + RD_LAT, 16'hA5A5);
        mcu(1'b0, 1'b1, 16'h0010, 16'h0000);
        idle(6);

        // internal read, idle bus
        t = cyc;
        exp_bus(t + 2, 1'b0, 16'h0020, 16'h0000);
        exp_i(t + 3 + RD_LAT, 1'b1, 16'h1234);
        int_acc(1'b0, 16'h0020, 16'h0000);
        idle(3);

        // internal write, idle bus, then MCU reads it back
        t = cyc;
        exp_bus(t + 2, 1'b1, 16'h0030, 16'hBEEF);
        exp_i(t + 3, 1'b0, 16'h0000);
        int_acc(1'b1, 16'h0030, 16'hBEEF);
        idle(2);
        t = cyc;
        exp_bus(t + 1, 1'b0, 16'h0030, 16'h0000);
        exp_m(t + 2 + RD_LAT, 16'hBEEF);
        mcu(1'b0, 1'b1, 16'h0030, 16'h0000);
        idle(5);

        // conflict: MCU read and internal read request in the same cycle
        t = cyc;
        exp_bus(t + 1, 1'b0, 16'h0010, 16'h0000);
        exp_bus(t + 2, 1'b0, 16'h0020, 16'h0000);
        exp_m(t + 2 + RD_LAT, 16'hA5A5);
        exp_i(t + 3 + RD_LAT, 1'b1, 16'h1234);
        exp_pt(t + 4, 0, 16'd0);
        fork
            mcu(1'b0, 1'b1, 16'h0010, 16'h0000);
            int_acc(1'b0, 16'h0020, 16'h0000);
        join
        idle(3);

        // three-cycle MCU burst: internal waits 3 cycles, below the limit
        t = cyc;
        for (int k = 0; k < 3; k++) exp_bus(t + 1 + k, 1'b1, 16'h0040 + 16'(k), 16'hC000 + 16'(k));
        exp_bus(t + 4, 1'b0, 16'h0020, 16'h0000);
        exp_i(t + 5 + RD_LAT, 1'b1, 16'h1234);
        exp_pt(t + 6, 0, 16'd0);
        fork
            mcu_burst(3, 16'h0040);
            int_acc(1'b0, 16'h0020, 16'h0000);
        join
        idle(3);

        // six-cycle MCU burst: starve sets after four pending cycles
        t = cyc;
        for (int k = 0; k < 6; k++) exp_bus(t + 1 + k, 1'b1, 16'h0050 + 16'(k), 16'hC000 + 16'(k));
        exp_bus(t + 7, 1'b1, 16'h0060, 16'h5A5A);
        exp_i(t + 8, 1'b0, 16'h0000);
        exp_pt(t + 5, 0, 16'd0);
        exp_pt(t + 6, 0, 16'd1);
        fork
            mcu_burst(6, 16'h0050);
            int_acc(1'b1, 16'h0060, 16'h5A5A);
        join
        idle(2);
        exp_pt(cyc, 0, 16'd1);
        tick();
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        exp_pt(cyc, 0, 16'd0);
        t = cyc;
        exp_bus(t + 1, 1'b0, 16'h0060, 16'h0000);
        exp_m(t + 2 + RD_LAT, 16'h5A5A);
        mcu(1'b0, 1'b1, 16'h0060, 16'h0000);
        idle(5);

        // illegal write+read strobe: only the write is issued
        t = cyc;
        exp_bus(t + 1, 1'b1, 16'h0070, 16'h7777);
        mcu(1'b1, 1'b1, 16'h0070, 16'h7777);
        idle(5);
        t = cyc;
        exp_bus(t + 1, 1'b0, 16'h0070, 16'h0000);
        exp_m(t + 2 + RD_LAT, 16'h7777);
        mcu(1'b0, 1'b1, 16'h0070, 16'h0000);
        idle(5);

        // reset with an MCU and an internal read in flight
        t = cyc;
        exp_bus(t + 1, 1'b0, 16'h0010, 16'h0000);
        exp_bus(t + 2, 1'b0, 16'h0020, 16'h0000);
        i_req = 1'b1; i_we = 1'b0; i_addr = 16'h0020;
        mcu(1'b0, 1'b1, 16'h0010, 16'h0000);
        idle(2);
        aclr  = 1'b1;
        i_req = 1'b0;
        exp_pt(t + 3, 1, 16'd0);
        exp_pt(t + 4, 1, 16'd0);
        idle(2);
        aclr = 1'b0;
        idle(6);

        // internal master re-requests after reset
        t = cyc;
        exp_bus(t + 2, 1'b0, 16'h0020, 16'h0000);
        exp_i(t + 3 + RD_LAT, 1'b1, 16'h1234);
        int_acc(1'b0, 16'h0020, 16'h0000);
        idle(5);

        done = 1'b1;
    end

endmodule
